// File: rtl/serial_div_pkg.sv
// serial_div_pkg: bit-order type and compare-and-subtract modular helpers shared by the divisibility lanes.
package serial_div_pkg;

   typedef enum logic {MSB_FIRST = 1'b0, LSB_FIRST = 1'b1} order_e;

   // Inputs are below 2*d, so a single conditional subtract is a full reduction.
   function automatic logic [7:0] mod_red(input logic [8:0] t, input logic [7:0] d);
      return (t >= {1'b0, d}) ? 8'(t - {1'b0, d}) : t[7:0];
   endfunction

   function automatic logic [7:0] mod_dbl(input logic [7:0] r, input logic b, input logic [7:0] d);
      return mod_red({r, b}, d);
   endfunction

   function automatic logic [7:0] mod_add(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
      return mod_red({1'b0, a} + {1'b0, b}, d);
   endfunction

endpackage

// File: rtl/serial_div_lane.sv
// serial_div_lane: one bit-serial lane tracking its stream value modulo DIVISOR in either bit order.
module serial_div_lane
   import serial_div_pkg::*;
#(
   parameter int DIVISOR = 3,
   localparam int RW = $clog2(DIVISOR)
) (
   input  logic          clk,
   input  logic          reset_tb,
   input  logic          in_valid,
   input  logic          in_start,
   input  logic          in_lsb_first,
   input  logic          din,
   output logic          dout,
   output logic [RW-1:0] rem
);

   localparam logic [7:0] DV = 8'(DIVISOR);

   logic [RW-1:0] r_q, r_d, p_q, p_d;
   order_e        ord_q, ord_d;
   logic          fresh_q, fresh_d, dout_q, dout_d;
   logic          st;
   logic [7:0]    r0, p0;

   // A lane that has not seen a bit since reset treats its next bit as a start.
   always_comb begin
      st = in_start | fresh_q;
      r0 = st ? 8'd0 : 8'(r_q);
      p0 = st ? 8'd1 : 8'(p_q);
      r_d = r_q;
      p_d = p_q;
      ord_d = ord_q;
      fresh_d = fresh_q;
      dout_d = dout_q;
      if (in_valid) begin
         ord_d = in_start ? order_e'(in_lsb_first) : ord_q;
         r_d = RW'(ord_d == LSB_FIRST ? mod_add(r0, din ? p0 : 8'd0, DV) : mod_dbl(r0, din, DV));
         p_d = RW'(mod_dbl(p0, 1'b0, DV));
         fresh_d = 1'b0;
         dout_d = (r_d == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_tb) begin
      if (!reset_tb) begin
         r_q <= '0;
         p_q <= RW'(1);
         ord_q <= MSB_FIRST;
         fresh_q <= 1'b1;
         dout_q <= 1'b0;
      end else begin
         r_q <= r_d;
         p_q <= p_d;
         ord_q <= ord_d;
         fresh_q <= fresh_d;
         dout_q <= dout_d;
      end
   end

   assign rem = r_q;
   assign dout = dout_q;

endmodule

// File: rtl/serial_div_by_n.sv
// serial_div_by_n: CHANNELS independent serial lanes reporting divisibility by DIVISOR one cycle after each bit.
module serial_div_by_n
   import serial_div_pkg::*;
#(
   parameter int DIVISOR = 3,
   parameter int CHANNELS = 4,
   localparam int RW = $clog2(DIVISOR)
) (
   input  logic                   clk,
   input  logic                   reset_tb,
   input  logic                   in_valid,
   input  logic [CHANNELS-1:0]    in_start,
   input  logic [CHANNELS-1:0]    in_lsb_first,
   input  logic [CHANNELS-1:0]    din,
   output logic                   out_valid,
   output logic [CHANNELS-1:0]    dout,
   output logic [CHANNELS*RW-1:0] rem
);

   logic out_valid_q, out_valid_d;

   always_comb out_valid_d = in_valid;

   always_ff @(posedge clk or negedge reset_tb) begin
      if (!reset_tb) out_valid_q <= 1'b0;
      else out_valid_q <= out_valid_d;
   end

   assign out_valid = out_valid_q;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      serial_div_lane #(.DIVISOR(DIVISOR)) u_lane (
         .clk          (clk),
         .reset_tb     (reset_tb),
         .in_valid     (in_valid),
         .in_start     (in_start[k]),
         .in_lsb_first (in_lsb_first[k]),
         .din          (din[k]),
         .dout         (dout[k]),
         .rem          (rem[k*RW +: RW])
      );
   end

endmodule

// File: tb/tb_serial_div_by_n.sv
// tb_serial_div_by_n: scoreboard bench driving divisor-3, -5 and -7 instances with shared lane stimulus.
module tb_serial_div_by_n;

   logic        clk = 1'b0, reset_tb = 1'b0, in_valid = 1'b0;
   logic [3:0]  in_start = '0, in_lsb_first = '0, din = '0;
   logic        ov_a, ov_b, ov_c;
   logic [3:0]  dout_a, dout_b, dout_c;
   logic [7:0]  rem_a;
   logic [11:0] rem_b, rem_c;

   always #5 clk = ~clk;

   serial_div_by_n #(.DIVISOR(3), .CHANNELS(4)) u_a (
      .clk(clk), .reset_tb(reset_tb), .in_valid(in_valid), .in_start(in_start),
      .in_lsb_first(in_lsb_first), .din(din), .out_valid(ov_a), .dout(dout_a), .rem(rem_a));
   serial_div_by_n #(.DIVISOR(5), .CHANNELS(4)) u_b (
      .clk(clk), .reset_tb(reset_tb), .in_valid(in_valid), .in_start(in_start),
      .in_lsb_first(in_lsb_first), .din(din), .out_valid(ov_b), .dout(dout_b), .rem(rem_b));
   serial_div_by_n #(.DIVISOR(7), .CHANNELS(4)) u_c (
      .clk(clk), .reset_tb(reset_tb), .in_valid(in_valid), .in_start(in_start),
      .in_lsb_first(in_lsb_first), .din(din), .out_valid(ov_c), .dout(dout_c), .rem(rem_c));

   typedef struct packed {
      logic [2:0][3:0][7:0] r;
      logic [2:0][3:0]      d;
      logic                 hv;
      logic [1:0]           hi;
      logic [7:0]           hr;
      logic                 hd;
   } exp_t;

   exp_t q[$];
   exp_t held;
   logic ov_exp;
   int   n_chk = 0, n_fail = 0;
   int   dv[3] = '{3, 5, 7};
   int   mr[3][4], mp[3][4];
   bit   mlsb[3][4], mfr[3][4];

   task automatic check(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic int get_rem(input int i, input int k);
      return i == 0 ? int'(rem_a[k*2 +: 2]) : i == 1 ? int'(rem_b[k*3 +: 3]) : int'(rem_c[k*3 +: 3]);
   endfunction

   function automatic int get_dout(input int i, input int k);
      return i == 0 ? int'(dout_a[k]) : i == 1 ? int'(dout_b[k]) : int'(dout_c[k]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) begin
            mr[i][k] = 0; mp[i][k] = 1; mlsb[i][k] = 0; mfr[i][k] = 1;
         end
   endtask

   task automatic model_step(input logic [3:0] s, input logic [3:0] l, input logic [3:0] b, output exp_t e);
      e = '0;
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) begin
            if (s[k] || mfr[i][k]) begin
               mr[i][k] = 0; mp[i][k] = 1;
               if (s[k]) mlsb[i][k] = l[k];
               mfr[i][k] = 0;
            end
            if (mlsb[i][k]) begin
               mr[i][k] = (mr[i][k] + int'(b[k]) * mp[i][k]) % dv[i];
               mp[i][k] = (mp[i][k] * 2) % dv[i];
            end else
               mr[i][k] = (mr[i][k] * 2 + int'(b[k])) % dv[i];
            e.r[i][k] = 8'(mr[i][k]);
            e.d[i][k] = (mr[i][k] == 0);
         end
   endtask

   task automatic beat(input logic v, input logic [3:0] s, input logic [3:0] l, input logic [3:0] b);
      exp_t e;
      @(posedge clk); #1;
      in_valid = v; in_start = s; in_lsb_first = l; din = b;
      if (v) begin
         model_step(s, l, b, e);
         q.push_back(e);
      end
   endtask

   // Valid beat with a hand-computed expectation for lane 0 of instance hi.
   task automatic hbeat(input logic [3:0] s, input logic [3:0] l, input logic [3:0] b,
                        input int hi, input int hr, input logic hd);
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; in_start = s; in_lsb_first = l; din = b;
      model_step(s, l, b, e);
      e.hv = 1'b1; e.hi = 2'(hi); e.hr = 8'(hr); e.hd = hd;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) beat(1'b0, 4'hf, 4'hf, 4'hf);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ov_a"}, int'(ov_a), 0);
      check({tag, "_ov_b"}, int'(ov_b), 0);
      check({tag, "_ov_c"}, int'(ov_c), 0);
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_rem_d%0d_l%0d", tag, dv[i], k), get_rem(i, k), 0);
            check($sformatf("%s_dout_d%0d_l%0d", tag, dv[i], k), get_dout(i, k), 0);
         end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #1;
      check("drain_before_reset", q.size(), 0);
      q.delete();
      reset_tb = 1'b0;
      #1;
      check_zero("reset");
      model_reset();
      held = '0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_start = 4'hf; din = 4'hf;
      @(posedge clk); #1;
      in_valid = 1'b0; in_start = '0; din = '0;
      @(negedge clk);
      reset_tb = 1'b1;
   endtask

   always @(posedge clk or negedge reset_tb)
      if (!reset_tb) ov_exp <= 1'b0;
      else ov_exp <= in_valid;

   always @(negedge clk) begin
      if (reset_tb) begin
         check("out_valid_d3", int'(ov_a), int'(ov_exp));
         check("out_valid_d5", int'(ov_b), int'(ov_exp));
         check("out_valid_d7", int'(ov_c), int'(ov_exp));
         if (ov_exp) begin
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL scoreboard_empty got=beat exp=none t=%0t", $time);
            end else held = q.pop_front();
         end
         for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
               check($sformatf("rem_d%0d_l%0d", dv[i], k), get_rem(i, k), int'(held.r[i][k]));
               check($sformatf("dout_d%0d_l%0d", dv[i], k), get_dout(i, k), int'(held.d[i][k]));
            end
         if (ov_exp && held.hv) begin
            check($sformatf("hand_rem_d%0d", dv[held.hi]), get_rem(int'(held.hi), 0), int'(held.hr));
            check($sformatf("hand_dout_d%0d", dv[held.hi]), get_dout(int'(held.hi), 0), int'(held.hd));
            held.hv = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      n_chk++; n_fail++;
      $display("FAIL watchdog got=running exp=finished t=%0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      model_reset();
      held = '0;
      #2;
      check_zero("por");
      @(negedge clk);
      @(negedge clk);
      reset_tb = 1'b1;
      // divisor 3, MSB-first 1,1,0
      hbeat(4'b0001, 4'b0000, 4'b0001, 0, 1, 1'b0);
      hbeat(4'b0000, 4'b0000, 4'b0001, 0, 0, 1'b1);
      hbeat(4'b0000, 4'b0000, 4'b0000, 0, 0, 1'b1);
      // divisor 5, LSB-first 1,0,1
      hbeat(4'b0001, 4'b0001, 4'b0001, 1, 1, 1'b0);
      hbeat(4'b0000, 4'b0000, 4'b0000, 1, 1, 1'b0);
      hbeat(4'b0000, 4'b0000, 4'b0001, 1, 0, 1'b1);
      // divisor 3 restart discards the earlier value
      hbeat(4'b0001, 4'b0000, 4'b0001, 0, 1, 1'b0);
      hbeat(4'b0000, 4'b0000, 4'b0000, 0, 2, 1'b0);
      hbeat(4'b0001, 4'b0000, 4'b0001, 0, 1, 1'b0);
      // idle gaps with junk start/data that must be ignored
      hbeat(4'b0001, 4'b0000, 4'b0001, 0, 1, 1'b0);
      idle(3);
      hbeat(4'b0000, 4'b0000, 4'b0001, 0, 0, 1'b1);
      idle(3);
      hbeat(4'b0000, 4'b0000, 4'b0000, 0, 0, 1'b1);
      // reset mid-stream, then a bit without start restarts from zero
      hbeat(4'b0001, 4'b0000, 4'b0001, 0, 1, 1'b0);
      hbeat(4'b0000, 4'b0000, 4'b0001, 0, 0, 1'b1);
      do_reset();
      hbeat(4'b0000, 4'b1111, 4'b0001, 0, 1, 1'b0);
      // mixed per-lane orders, sparse restarts and gaps
      beat(1'b1, 4'b1111, 4'b1010, 4'b1111);
      for (int n = 0; n < 300; n++) begin
         logic [3:0] s;
         for (int k = 0; k < 4; k++) s[k] = ($urandom_range(0, 40) == 0);
         beat($urandom_range(0, 3) != 0, s, 4'($urandom), 4'($urandom));
         if (n == 150) do_reset();
      end
      idle(4);
      check("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
